// File: rtl/tpu_pkg.sv
// Shared defaults and types for the TPU input-feed / matrix-multiply slice.
package tpu_pkg;

  localparam int TPU_DATA_WIDTH = 16;
  localparam int TPU_PSUM_WIDTH = 2 * TPU_DATA_WIDTH;
  localparam int TPU_ADDR_WIDTH = 8;

  typedef logic signed [TPU_DATA_WIDTH-1:0] data_t;
  typedef logic signed [TPU_PSUM_WIDTH-1:0] psum_t;

  // Read-phase sequencer states
  typedef enum logic {
    RD_IDLE,
    RD_BUSY
  } rd_state_t;

endpackage

// File: rtl/tpu_input_mmu_if.sv
// Handshake/data bundle between the input feeder, weight FIFO and the MMU.
interface tpu_input_mmu_if
  import tpu_pkg::*;
#(
  parameter int SYS_ROW    = 4,
  parameter int SYS_COL    = 4,
  parameter int DATA_WIDTH = TPU_DATA_WIDTH
);
  localparam int PSUM_WIDTH = 2 * DATA_WIDTH;

  logic                                 wr_en_in;
  logic                                 rd_en_in;
  logic [DATA_WIDTH-1:0]                num_row;
  logic [SYS_ROW-1:0][DATA_WIDTH-1:0]   wr_data;
  logic [SYS_COL-1:0]                   w_wen;
  logic [SYS_COL-1:0][DATA_WIDTH-1:0]   w_in;
  logic                                 mmu_en;
  logic [SYS_COL-1:0][PSUM_WIDTH-1:0]   psum_out;
  logic [SYS_COL-1:0]                   en_out;
  logic                                 wr_done;

  modport master (
    output wr_en_in, rd_en_in, num_row, wr_data, w_wen, w_in, mmu_en,
    input  psum_out, en_out, wr_done
  );

  modport slave (
    input  wr_en_in, rd_en_in, num_row, wr_data, w_wen, w_in, mmu_en,
    output psum_out, en_out, wr_done
  );

endinterface

// File: rtl/tpu_input_mmu_sys_pe.sv
// Weight-stationary processing element: weight shift register, input
// pass-through register and signed multiply-accumulate psum register.
module sys_pe
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH = TPU_DATA_WIDTH,
  parameter int PSUM_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic                         w_en,
  input  logic signed [DATA_WIDTH-1:0] w_in,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [PSUM_WIDTH-1:0] psum_in,
  output logic signed [DATA_WIDTH-1:0] w_out,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [PSUM_WIDTH-1:0] psum_out
);

  // Weight shifts independently of compute; MAC uses the pre-edge weight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_out    <= '0;
      a_out    <= '0;
      psum_out <= '0;
    end else begin
      if (w_en) begin
        w_out <= w_in;
      end
      if (en) begin
        a_out    <= a_in;
        psum_out <= psum_in + a_in * w_out;
      end
    end
  end

endmodule

// File: rtl/tpu_input_mmu.sv
// Input buffer controller, banked input memory and SYS_ROW x SYS_COL
// weight-stationary systolic array. Rows are written one per cycle into the
// banks, then streamed out with a diagonal skew into the array.
module tpu_input_mmu
  import tpu_pkg::*;
#(
  parameter int SYS_ROW    = 4,
  parameter int SYS_COL    = 4,
  parameter int DATA_WIDTH = TPU_DATA_WIDTH,
  parameter int ADDR_WIDTH = TPU_ADDR_WIDTH,
  parameter int ACCUM_SIZE = 1024
) (
  input  logic           clk,
  input  logic           rstn,
  tpu_input_mmu_if.slave bus
);

  localparam int PSUM_WIDTH = 2 * DATA_WIDTH;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int LIMIT      = (ACCUM_SIZE < DEPTH) ? ACCUM_SIZE : DEPTH;
  localparam int CW         = $clog2(LIMIT + 1);
  localparam int KW         = $clog2(LIMIT + SYS_ROW);
  localparam int ENW        = SYS_ROW + SYS_COL - 1;

  // ---------------- write controller ----------------
  logic          wr_en_q;
  logic [CW-1:0] n_q;
  logic [CW-1:0] wp;
  logic          wr_done;
  logic [CW-1:0] n_sample;
  logic          wr_start;
  logic [CW-1:0] n_eff;
  logic [CW-1:0] wp_eff;
  logic          wr_fire;

  // First write happens in the same cycle wr_en_in rises, so the freshly
  // sampled count and a zero pointer are bypassed into this cycle's decision.
  always_comb begin
    if (32'(bus.num_row) > 32'(LIMIT)) begin
      n_sample = CW'(LIMIT);
    end else begin
      n_sample = CW'(bus.num_row);
    end
    wr_start = bus.wr_en_in & ~wr_en_q;
    n_eff    = wr_start ? n_sample : n_q;
    wp_eff   = wr_start ? '0 : wp;
    wr_fire  = bus.wr_en_in && (wp_eff < n_eff);
  end

  // Write pointer, latched row count and batch-complete flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en_q <= 1'b0;
      n_q     <= '0;
      wp      <= '0;
      wr_done <= 1'b0;
    end else begin
      wr_en_q <= bus.wr_en_in;
      if (wr_start) begin
        n_q     <= n_sample;
        wp      <= '0;
        wr_done <= (n_sample == '0);
      end
      if (wr_fire) begin
        wp      <= wp_eff + 1'b1;
        wr_done <= ((wp_eff + 1'b1) == n_eff);
      end
    end
  end

  // ---------------- read sequencer ----------------
  rd_state_t     rd_state;
  logic [KW-1:0] rd_cnt;
  logic [KW-1:0] rd_last;
  logic [KW-1:0] k;
  logic          rd_start;
  logic          rd_active;

  // Sequence offset k counts cycles since start; bank r serves address k-r
  always_comb begin
    rd_start  = bus.rd_en_in && (rd_state == RD_IDLE) && wr_done && (n_q != '0);
    rd_last   = KW'(n_q) + KW'(SYS_ROW - 1) - KW'(1);
    k         = rd_start ? '0 : rd_cnt;
    rd_active = rd_start || (rd_state == RD_BUSY);
  end

  // Busy for N+SYS_ROW-1 cycles including the start cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state <= RD_IDLE;
      rd_cnt   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (rd_start) begin
            rd_state <= (rd_last == '0) ? RD_IDLE : RD_BUSY;
            rd_cnt   <= KW'(1);
          end
        end
        RD_BUSY: begin
          if (rd_cnt == rd_last) begin
            rd_state <= RD_IDLE;
            rd_cnt   <= '0;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        default: begin
          rd_state <= RD_IDLE;
          rd_cnt   <= '0;
        end
      endcase
    end
  end

  // ---------------- memory banks ----------------
  logic signed [DATA_WIDTH-1:0] rd_data [SYS_ROW];

  for (genvar r = 0; r < SYS_ROW; r++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [KW-1:0]         off;
    logic                  rd_hit;

    // Diagonal skew: bank r lags bank 0 by r cycles
    always_comb begin
      off    = k - KW'(r);
      rd_hit = rd_active && (k >= KW'(r)) && (off < KW'(n_q));
    end

    // Synchronous bank write, one row element per bank
    always_ff @(posedge clk) begin
      if (wr_fire) begin
        mem[ADDR_WIDTH'(wp_eff)] <= bus.wr_data[r];
      end
    end

    // Registered read; zero when the bank was not addressed
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rd_data[r] <= '0;
      end else begin
        rd_data[r] <= rd_hit ? mem[ADDR_WIDTH'(off)] : '0;
      end
    end
  end

  // ---------------- systolic array ----------------
  logic signed [DATA_WIDTH-1:0] a_h [SYS_ROW][SYS_COL+1];
  logic signed [DATA_WIDTH-1:0] w_h [SYS_ROW+1][SYS_COL];
  logic signed [PSUM_WIDTH-1:0] p_h [SYS_ROW+1][SYS_COL];

  for (genvar r = 0; r < SYS_ROW; r++) begin : g_row
    assign a_h[r][0] = rd_data[r];
    for (genvar c = 0; c < SYS_COL; c++) begin : g_col
      sys_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .PSUM_WIDTH (PSUM_WIDTH)
      ) u_pe (
        .clk      (clk),
        .rstn     (rstn),
        .en       (bus.mmu_en),
        .w_en     (bus.w_wen[c]),
        .w_in     (w_h[r][c]),
        .a_in     (a_h[r][c]),
        .psum_in  (p_h[r][c]),
        .w_out    (w_h[r+1][c]),
        .a_out    (a_h[r][c+1]),
        .psum_out (p_h[r+1][c])
      );
    end
  end

  for (genvar c = 0; c < SYS_COL; c++) begin : g_edge
    assign w_h[0][c]        = bus.w_in[c];
    assign p_h[0][c]        = '0;
    assign bus.psum_out[c]  = p_h[SYS_ROW][c];
  end

  // Right-edge inputs and bottom-edge weights leave the array unused
  logic unused_tail;
  always_comb begin
    unused_tail = 1'b0;
    for (int unsigned r = 0; r < SYS_ROW; r++) begin
      unused_tail = unused_tail ^ (^a_h[r][SYS_COL]);
    end
    for (int unsigned c = 0; c < SYS_COL; c++) begin
      unused_tail = unused_tail ^ (^w_h[SYS_ROW][c]);
    end
  end

  // ---------------- output valid ----------------
  logic [ENW-1:0] en_sr;

  // mmu_en delay line; column c taps the SYS_ROW+c delayed copy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_sr <= '0;
    end else begin
      en_sr <= {en_sr[ENW-2:0], bus.mmu_en};
    end
  end

  for (genvar c = 0; c < SYS_COL; c++) begin : g_en
    assign bus.en_out[c] = en_sr[SYS_ROW+c-1];
  end

  assign bus.wr_done = wr_done;

endmodule

// File: tb/tb_tpu_input_mmu.sv
// Self-checking bench for tpu_input_mmu: a row-by-row matrix-product model
// (psum[i][c] = sum_r A[i][r]*W[r][c]) drives expected outputs at the
// documented output cycle for each row and column.
module tb_tpu_input_mmu;
  import tpu_pkg::*;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  always #5 clk = ~clk;

  tpu_input_mmu_if #(.SYS_ROW(R), .SYS_COL(C), .DATA_WIDTH(DW)) bus ();

  tpu_input_mmu #(
    .SYS_ROW    (R),
    .SYS_COL    (C),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (8),
    .ACCUM_SIZE (1024)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Reference model state
  data_t A [260][R];
  data_t W [R][C];
  int    n_eff = 0;

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en_in = 1'b0;
    bus.rd_en_in = 1'b0;
    bus.num_row  = '0;
    bus.wr_data  = '0;
    bus.w_wen    = '0;
    bus.w_in     = '0;
    bus.mmu_en   = 1'b0;
  endtask

  function automatic psum_t exp_row(input int i, input int c);
    psum_t acc;
    acc = '0;
    if (i < 0 || i >= n_eff) return '0;
    for (int r = 0; r < R; r++) acc = acc + psum_t'(A[i][r]) * psum_t'(W[r][c]);
    return acc;
  endfunction

  task automatic weight_cycle(input logic [C-1:0] wen, input logic [C-1:0][DW-1:0] win);
    bus.w_wen = wen;
    bus.w_in  = win;
    for (int c = 0; c < C; c++) begin
      if (wen[c]) begin
        for (int r = R - 1; r > 0; r--) W[r][c] = W[r-1][c];
        W[0][c] = data_t'(win[c]);
      end
    end
    tick();
    bus.w_wen = '0;
    bus.w_in  = '0;
  endtask

  task automatic write_batch(input int nr, input int cycles, input string tag);
    int expn;
    logic want;
    expn = (nr > 256) ? 256 : nr;
    bus.num_row = 16'(nr);
    for (int i = 0; i < cycles; i++) begin
      bus.wr_en_in = 1'b1;
      for (int r = 0; r < R; r++) bus.wr_data[r] = A[i][r];
      tick();
      want = (i + 1 >= expn);
      total++;
      if (bus.wr_done !== want) begin
        bad++;
        $display("FAIL %s wr_done after write %0d: got %b want %b", tag, i, bus.wr_done, want);
      end
    end
    bus.wr_en_in = 1'b0;
    bus.wr_data  = '0;
    if (cycles >= expn) n_eff = expn;
  endtask

  // Pulse rd_en_in with mmu_en high; optional second pulse at cycle s+extra
  task automatic run_matmul(input int extra, input string tag);
    int i;
    psum_t want;
    bus.mmu_en   = 1'b1;
    bus.rd_en_in = 1'b1;
    for (int t = 1; t <= n_eff + R + C + 3; t++) begin
      tick();
      bus.rd_en_in = (t == extra);
      for (int c = 0; c < C; c++) begin
        i = t - R - c - 1;
        if (i >= 0) begin
          want = exp_row(i, c);
          total++;
          if (bus.psum_out[c] !== want) begin
            bad++;
            $display("FAIL %s psum_out[%0d] row %0d: got %h want %h", tag, c, i, bus.psum_out[c], want);
          end
        end
      end
    end
    bus.rd_en_in = 1'b0;
    bus.mmu_en   = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    total++;
    if (bus.psum_out !== '0) begin
      bad++;
      $display("FAIL %s psum_out: got %h want 0", tag, bus.psum_out);
    end
    total++;
    if (bus.en_out !== '0) begin
      bad++;
      $display("FAIL %s en_out: got %b want 0", tag, bus.en_out);
    end
    total++;
    if (bus.wr_done !== 1'b0) begin
      bad++;
      $display("FAIL %s wr_done: got %b want 0", tag, bus.wr_done);
    end
  endtask

  task automatic clear_weight_model();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) W[r][c] = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    clear_weight_model();
    #2 rstn = 1'b0;
    tick();
    tick();
    check_zero_outputs("reset_state");
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_read_guard();
    logic [C-1:0][DW-1:0] ones;
    for (int c = 0; c < C; c++) ones[c] = 16'd1;
    for (int k = 0; k < R; k++) weight_cycle('1, ones);
    for (int i = 0; i < 8; i++)
      for (int r = 0; r < R; r++) A[i][r] = data_t'($urandom_range(1, 500));
    write_batch(8, 2, "guard_partial");
    bus.mmu_en   = 1'b1;
    bus.rd_en_in = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      bus.rd_en_in = 1'b0;
      total++;
      if (bus.psum_out !== '0) begin
        bad++;
        $display("FAIL guard_no_read cycle %0d: got %h want 0", t, bus.psum_out);
      end
    end
    bus.mmu_en = 1'b0;
    tick();
  endtask

  task automatic test_write();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < R; j++) A[i][j] = data_t'(4 * j + i);
    write_batch(4, 4, "write4");
  endtask

  task automatic test_weight_load();
    logic [C-1:0][DW-1:0] v;
    for (int c = 0; c < C; c++) v[c] = 16'(c + 1);
    for (int k = 0; k < R; k++) weight_cycle('1, v);
  endtask

  task automatic test_matmul();
    run_matmul(0, "matmul");
  endtask

  task automatic test_back_to_back();
    weight_cycle('1, '0);
    run_matmul(2, "row0_zero_busy_pulse");
  endtask

  task automatic test_valid();
    logic [C-1:0] want;
    bus.mmu_en = 1'b0;
    repeat (R + C + 2) tick();
    total++;
    if (bus.en_out !== '0) begin
      bad++;
      $display("FAIL valid_idle: got %b want 0", bus.en_out);
    end
    bus.mmu_en = 1'b1;
    for (int t = 1; t <= R + C + 1; t++) begin
      tick();
      for (int c = 0; c < C; c++) want[c] = (t >= R + c);
      total++;
      if (bus.en_out !== want) begin
        bad++;
        $display("FAIL valid_rise t=%0d: got %b want %b", t, bus.en_out, want);
      end
    end
    bus.mmu_en = 1'b0;
    for (int t = 1; t <= R + C + 1; t++) begin
      tick();
      for (int c = 0; c < C; c++) want[c] = (t < R + c);
      total++;
      if (bus.en_out !== want) begin
        bad++;
        $display("FAIL valid_fall t=%0d: got %b want %b", t, bus.en_out, want);
      end
    end
  endtask

  task automatic test_zero_rows();
    write_batch(0, 1, "zero_rows");
    run_matmul(0, "zero_rows_read");
  endtask

  task automatic test_signed();
    logic [C-1:0][DW-1:0] v;
    for (int c = 0; c < C; c++) v[c] = 16'hFFFF;
    for (int k = 0; k < R; k++) weight_cycle('1, v);
    A[0][0] = 16'sd2;
    for (int r = 1; r < R; r++) A[0][r] = '0;
    write_batch(1, 1, "signed_write");
    run_matmul(0, "signed");
  endtask

  task automatic test_random();
    logic [C-1:0][DW-1:0] v;
    int n;
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 6; k++) begin
        for (int c = 0; c < C; c++) v[c] = 16'($urandom);
        weight_cycle(C'($urandom), v);
      end
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++)
        for (int r = 0; r < R; r++) A[i][r] = data_t'($urandom);
      write_batch(n, n + $urandom_range(0, 2), "rand_write");
      run_matmul((it == 1) ? 3 : 0, "rand_matmul");
    end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 260; i++)
      for (int r = 0; r < R; r++) A[i][r] = data_t'($urandom);
    write_batch(300, 260, "clamp_write");
    run_matmul(0, "clamp_matmul");
  endtask

  task automatic test_reset_midstream();
    logic [C-1:0][DW-1:0] v;
    for (int c = 0; c < C; c++) v[c] = 16'(c + 3);
    for (int k = 0; k < R; k++) weight_cycle('1, v);
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < R; r++) A[i][r] = data_t'($urandom_range(1, 1000));
    write_batch(4, 4, "mid_write");
    bus.mmu_en   = 1'b1;
    bus.rd_en_in = 1'b1;
    tick();
    bus.rd_en_in = 1'b0;
    repeat (6) tick();
    #3 rstn = 1'b0;
    #1;
    check_zero_outputs("reset_async");
    tick();
    rstn = 1'b1;
    idle_inputs();
    clear_weight_model();
    n_eff = 0;
    tick();
    for (int i = 0; i < 3; i++)
      for (int r = 0; r < R; r++) A[i][r] = data_t'($urandom_range(1, 1000));
    write_batch(3, 3, "post_reset_write");
    run_matmul(0, "post_reset_zero_weights");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_read_guard();
    test_write();
    test_weight_load();
    test_matmul();
    test_back_to_back();
    test_valid();
    test_zero_rows();
    test_signed();
    test_random();
    test_clamp();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
